// File: rtl/wide_alu_sequencer_pkg.sv
// Shared definitions for the 16-bit-on-8-bit ALU sequencer: op and state
// encodings, the ALU's 4-bit {op,funct} codes and small decode helpers.
package wide_alu_sequencer_pkg;

    localparam int unsigned HALF_W_C = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_LSH  = 3'd1,
        OP_RSH  = 3'd2,
        OP_XOR  = 3'd3,
        OP_AND  = 3'd4,
        OP_CMP  = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } wide_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    // Existing byte ALU {OP,funct} codes.
    localparam logic [3:0] kNOP     = 4'b0000;
    localparam logic [3:0] kADD     = 4'b0001;
    localparam logic [3:0] kLSH     = 4'b0100;
    localparam logic [3:0] kRSH     = 4'b0101;
    localparam logic [3:0] kXOR     = 4'b1000;
    localparam logic [3:0] kAND     = 4'b1001;
    localparam logic [3:0] kCOMPARE = 4'b1010;

    function automatic logic [3:0] alu_code(input wide_op_t op);
        case (op)
            OP_ADD:  return kADD;
            OP_LSH:  return kLSH;
            OP_RSH:  return kRSH;
            OP_XOR:  return kXOR;
            OP_AND:  return kAND;
            OP_CMP:  return kCOMPARE;
            default: return kNOP;
        endcase
    endfunction

    // Ops whose second pass consumes the first pass's carry/shift-out bit.
    function automatic logic chains_carry(input wide_op_t op);
        return (op == OP_ADD) || (op == OP_LSH) || (op == OP_RSH);
    endfunction

    // Right shifts must process the upper byte first so its low bit can
    // feed the lower byte.
    function automatic logic msw_first(input wide_op_t op);
        return (op == OP_RSH);
    endfunction

    function automatic logic is_legal(input wide_op_t op);
        return (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// Bundle of the decode-side handshake and the byte-ALU drive/return lines.
// master: decode + ALU side; slave: the sequencer.
interface wide_alu_sequencer_if;
    logic        Start;
    logic [2:0]  WideOp;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        CarryOut;
    logic        ZeroOut;
    logic [7:0]  AluA;
    logic [7:0]  AluB;
    logic [1:0]  AluOp;
    logic [1:0]  AluFunct;
    logic        AluScIn;
    logic [7:0]  AluOut;
    logic        AluScOut;

    modport master (
        output Start, WideOp, OpA, OpB, AluOut, AluScOut,
        input  Busy, Done, Result, CarryOut, ZeroOut,
        input  AluA, AluB, AluOp, AluFunct, AluScIn
    );

    modport slave (
        input  Start, WideOp, OpA, OpB, AluOut, AluScOut,
        output Busy, Done, Result, CarryOut, ZeroOut,
        output AluA, AluB, AluOp, AluFunct, AluScIn
    );
endinterface

// File: rtl/wide_alu_sequencer_byte_sel.sv
// Combinational ALU input mux: picks the operand byte half for the current
// pass, the op code and the shift/carry input. Drives a no-op outside the
// two ALU passes. Optional macro WIDE_ROTATE_EN turns shifts into rotates.
module wide_alu_byte_sel
    import wide_alu_sequencer_pkg::*;
(
    input  seq_state_t  state_i,
    input  wide_op_t    op_i,
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    input  logic        carry_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [3:0]  alu_code_o,
    output logic        alu_sc_in_o
);

    logic first_cin_s;
    logic hi_pass_s;

    // Carry/shift bit entering the first pass (wrap-around bit when rotating).
    always_comb begin
`ifdef WIDE_ROTATE_EN
        if (op_i == OP_LSH) begin
            first_cin_s = op_a_i[15];
        end else if (op_i == OP_RSH) begin
            first_cin_s = op_a_i[0];
        end else begin
            first_cin_s = 1'b0;
        end
`else
        first_cin_s = 1'b0;
`endif
    end

    // Byte-half selection and ALU drive for the active pass.
    always_comb begin
        alu_a_o     = 8'h00;
        alu_b_o     = 8'h00;
        alu_code_o  = kNOP;
        alu_sc_in_o = 1'b0;
        hi_pass_s   = 1'b0;
        if ((state_i == S_FIRST) || (state_i == S_SECOND)) begin
            hi_pass_s  = msw_first(op_i) ? (state_i == S_FIRST) : (state_i == S_SECOND);
            alu_a_o    = hi_pass_s ? op_a_i[15:8] : op_a_i[7:0];
            alu_b_o    = hi_pass_s ? op_b_i[15:8] : op_b_i[7:0];
            alu_code_o = alu_code(op_i);
            if (state_i == S_FIRST) begin
                alu_sc_in_o = first_cin_s;
            end else begin
                alu_sc_in_o = chains_carry(op_i) ? carry_i : 1'b0;
            end
        end else begin
            hi_pass_s = 1'b0;
        end
    end

endmodule

// File: rtl/wide_alu_sequencer.sv
// Runs 16-bit ADD/LSH/RSH/XOR/AND/CMP as two passes over the 8-bit ALU.
// Start accepted in IDLE -> FIRST -> SECOND -> DONE -> IDLE; Done is raised
// as the sequencer returns to IDLE so a new Start may be taken that cycle.
// Optional macro: WIDE_ROTATE_EN (see wide_alu_byte_sel).
module wide_alu_sequencer
    import wide_alu_sequencer_pkg::*;
#(
    parameter int unsigned HALF_W      = 8,
    parameter bit          STICKY_DONE = 1'b0
) (
    input logic                  CLK,
    input logic                  Reset,
    wide_alu_sequencer_if.slave  bus
);

    if (HALF_W != HALF_W_C) begin : g_half_w_check
        $error("wide_alu_sequencer: HALF_W must be 8");
    end

    seq_state_t  state_q, state_d;
    wide_op_t    op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        carry_q, carry_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic        zero_q, zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  alu_code_s;

    wide_alu_byte_sel u_byte_sel (
        .state_i     (state_q),
        .op_i        (op_q),
        .op_a_i      (a_q),
        .op_b_i      (b_q),
        .carry_i     (carry_q),
        .alu_a_o     (bus.AluA),
        .alu_b_o     (bus.AluB),
        .alu_code_o  (alu_code_s),
        .alu_sc_in_o (bus.AluScIn)
    );

    assign bus.AluOp    = alu_code_s[3:2];
    assign bus.AluFunct = alu_code_s[1:0];
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Result   = result_q;
    assign bus.CarryOut = cout_q;
    assign bus.ZeroOut  = zero_q;

    // Sequencer next state, operand latching and result capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        byte_d   = byte_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = STICKY_DONE ? done_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    op_d    = wide_op_t'(bus.WideOp);
                    a_d     = bus.OpA;
                    b_d     = bus.OpB;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_FIRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRST: begin
                byte_d  = bus.AluOut;
                carry_d = bus.AluScOut;
                state_d = S_SECOND;
            end
            S_SECOND: begin
                if (is_legal(op_q)) begin
                    result_d = msw_first(op_q) ? {byte_q, bus.AluOut} : {bus.AluOut, byte_q};
                    cout_d   = chains_carry(op_q) ? bus.AluScOut : 1'b0;
                end else begin
                    result_d = 16'h0000;
                    cout_d   = 1'b0;
                end
                zero_d  = (result_d == 16'h0000);
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            carry_q  <= 1'b0;
            byte_q   <= 8'h00;
            result_q <= 16'h0000;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            byte_q   <= byte_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Bench for wide_alu_sequencer: behavioural byte ALU, 16-bit reference
// model with cycle-level expectations, directed vectors with literal values.
module tb_wide_alu_sequencer;
    import wide_alu_sequencer_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    wide_alu_sequencer_if bus0 ();
    wide_alu_sequencer_if bus1 ();

    wide_alu_sequencer #(.HALF_W(8), .STICKY_DONE(1'b0)) dut0 (
        .CLK(CLK), .Reset(Reset), .bus(bus0.slave));
    wide_alu_sequencer #(.HALF_W(8), .STICKY_DONE(1'b1)) dut1 (
        .CLK(CLK), .Reset(Reset), .bus(bus1.slave));

    // Byte ALU behaviour: returns {sc_out, out}.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] code, input logic sc);
        case (code)
            kADD:     return {1'b0, a} + {1'b0, b} + {8'd0, sc};
            kLSH:     return {a[7], a[6:0], sc};
            kRSH:     return {a[0], sc, a[7:1]};
            kXOR:     return {1'b0, a ^ b};
            kAND:     return {1'b0, a & b};
            kCOMPARE: return {1'b0, (a == b) ? 8'h00 : 8'h01};
            default:  return 9'h000;
        endcase
    endfunction

    assign {bus0.AluScOut, bus0.AluOut} = alu_ref(bus0.AluA, bus0.AluB, {bus0.AluOp, bus0.AluFunct}, bus0.AluScIn);
    assign {bus1.AluScOut, bus1.AluOut} = alu_ref(bus1.AluA, bus1.AluB, {bus1.AluOp, bus1.AluFunct}, bus1.AluScIn);

    // 16-bit reference: returns {carry, result}.
    function automatic logic [16:0] wide_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic rot;
`ifdef WIDE_ROTATE_EN
        rot = 1'b1;
`else
        rot = 1'b0;
`endif
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a[15], a[14:0], rot & a[15]};
            3'd2:    return {a[0], rot & a[0], a[15:1]};
            3'd3:    return {1'b0, a ^ b};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, (a[15:8] != b[15:8]) ? 8'h01 : 8'h00, (a[7:0] != b[7:0]) ? 8'h01 : 8'h00};
            default: return 17'h00000;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model of dut0: remaining busy cycles, done pulse, result regs.
    int          rem;
    logic        m_done;
    logic [16:0] m_pend;
    logic [15:0] m_res;
    logic        m_cy, m_z;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rem <= 0; m_done <= 1'b0; m_pend <= 17'h0;
            m_res <= 16'h0; m_cy <= 1'b0; m_z <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (rem == 0) begin
                if (bus0.Start) begin
                    rem    <= 3;
                    m_pend <= wide_ref(bus0.WideOp, bus0.OpA, bus0.OpB);
                end
            end else begin
                rem <= rem - 1;
                if (rem == 2) begin
                    m_res <= m_pend[15:0];
                    m_cy  <= m_pend[16];
                    m_z   <= (m_pend[15:0] == 16'h0000);
                end
                if (rem == 1) m_done <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of dut0 against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy",   16'(bus0.Busy),     16'(rem != 0));
            check("done",   16'(bus0.Done),     16'(m_done));
            check("result", bus0.Result,        m_res);
            check("carry",  16'(bus0.CarryOut), 16'(m_cy));
            check("zero",   16'(bus0.ZeroOut),  16'(m_z));
            if (rem == 0 || rem == 1) begin
                check("idle_alu_a",  16'(bus0.AluA),    16'h0000);
                check("idle_alu_b",  16'(bus0.AluB),    16'h0000);
                check("idle_sc_in",  16'(bus0.AluScIn), 16'h0000);
                check("idle_code",   16'({bus0.AluOp, bus0.AluFunct}), 16'(kNOP));
            end
        end
    end

    task automatic drive(input bit sel, input logic st, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (sel) begin
            bus1.Start = st; bus1.WideOp = op; bus1.OpA = a; bus1.OpB = b;
        end else begin
            bus0.Start = st; bus0.WideOp = op; bus0.OpA = a; bus0.OpB = b;
        end
    endtask

    // Wait for Done (bounded); lat = negedges after the accept edge.
    task automatic wait_done(input bit sel, output int lat);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if ((sel ? bus1.Done : bus0.Done) === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_err++;
            $display("FAIL done_timeout: got no Done expected Done within 12 cycles");
        end
    endtask

    // Issue one op (Start for one sampled edge, then scramble inputs).
    task automatic run(input bit sel, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int lat);
        @(posedge CLK); #1 drive(sel, 1'b1, op, a, b);
        @(posedge CLK); #1 drive(sel, 1'b0, 3'd5, 16'hDEAD, 16'hBEEF);
        wait_done(sel, lat);
    endtask

    task automatic expect0(input string name, input logic [15:0] res, input logic cy, input logic z);
        check({name, "_res"},   bus0.Result,        res);
        check({name, "_carry"}, 16'(bus0.CarryOut), 16'(cy));
        check({name, "_zero"},  16'(bus0.ZeroOut),  16'(z));
    endtask

    int lat;
    int nd;
    logic [15:0] seen;

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        chk_en = 1'b1;
        expect0("reset", 16'h0000, 1'b0, 1'b1);
        check("reset_busy", 16'(bus0.Busy), 16'h0000);

        run(1'b0, 3'd0, 16'h00FF, 16'h0001, lat);
        check("add1_latency", 16'(lat), 16'd3);
        expect0("add1", 16'h0100, 1'b0, 1'b0);
        run(1'b0, 3'd0, 16'hFFFF, 16'h0001, lat);
        expect0("add2", 16'h0000, 1'b1, 1'b1);
`ifdef WIDE_ROTATE_EN
        run(1'b0, 3'd1, 16'h8081, 16'h0000, lat); expect0("lsh", 16'h0103, 1'b1, 1'b0);
        run(1'b0, 3'd2, 16'h0181, 16'h0000, lat); expect0("rsh", 16'h80C0, 1'b1, 1'b0);
`else
        run(1'b0, 3'd1, 16'h8081, 16'h0000, lat); expect0("lsh", 16'h0102, 1'b1, 1'b0);
        run(1'b0, 3'd2, 16'h0181, 16'h0000, lat); expect0("rsh", 16'h00C0, 1'b1, 1'b0);
`endif
        run(1'b0, 3'd5, 16'h1234, 16'h1234, lat); expect0("cmp_eq", 16'h0000, 1'b0, 1'b1);
        run(1'b0, 3'd5, 16'h1234, 16'h1235, lat); expect0("cmp_ne", 16'h0001, 1'b0, 1'b0);
        run(1'b0, 3'd3, 16'hF0F0, 16'h0FF0, lat); expect0("xor", 16'hFF00, 1'b0, 1'b0);

        // Back-to-back: Start raised in the Done cycle.
        drive(1'b0, 1'b1, 3'd4, 16'hF0F0, 16'h0FF0);
        @(posedge CLK); #1 drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        wait_done(1'b0, lat);
        check("b2b_latency", 16'(lat), 16'd3);
        expect0("and", 16'h00F0, 1'b0, 1'b0);

        run(1'b0, 3'd6, 16'h1234, 16'h5678, lat);
        check("ill6_latency", 16'(lat), 16'd3);
        expect0("ill6", 16'h0000, 1'b0, 1'b1);

        // Start while busy is ignored.
        @(posedge CLK); #1 drive(1'b0, 1'b1, 3'd0, 16'h1111, 16'h2222);
        @(posedge CLK); #1 drive(1'b0, 1'b1, 3'd3, 16'hAAAA, 16'h5555);
        @(posedge CLK); #1 drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        nd = 0; seen = 16'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus0.Done) begin nd++; seen = bus0.Result; end
        end
        check("busy_start_dones", 16'(nd), 16'd1);
        check("busy_start_res", seen, 16'h3333);

        // Reset during SECOND.
        @(posedge CLK); #1 drive(1'b0, 1'b1, 3'd0, 16'h0F0F, 16'h0101);
        @(posedge CLK); #1 drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        @(posedge CLK); #1 Reset = 1'b1;
        #1;
        check("midrst_busy", 16'(bus0.Busy), 16'h0000);
        check("midrst_done", 16'(bus0.Done), 16'h0000);
        expect0("midrst", 16'h0000, 1'b0, 1'b1);
        @(posedge CLK); #1 Reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (bus0.Done) nd++;
        end
        check("midrst_no_done", 16'(nd), 16'd0);
        run(1'b0, 3'd0, 16'h0F0F, 16'h0101, lat);
        check("postrst_latency", 16'(lat), 16'd3);
        expect0("postrst", 16'h1010, 1'b0, 1'b0);

        // Sticky Done instance.
        run(1'b1, 3'd0, 16'h0001, 16'h0002, lat);
        check("sticky_latency", 16'(lat), 16'd3);
        check("sticky_res", bus1.Result, 16'h0003);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (bus1.Done) nd++;
        end
        check("sticky_hold", 16'(nd), 16'd5);
        @(posedge CLK); #1 drive(1'b1, 1'b1, 3'd7, 16'h1234, 16'h5678);
        @(posedge CLK); #1 drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        check("sticky_drop_done", 16'(bus1.Done), 16'h0000);
        check("sticky_drop_busy", 16'(bus1.Busy), 16'h0001);
        wait_done(1'b1, lat);
        check("ill7_latency", 16'(lat), 16'd3);
        check("ill7_res", bus1.Result, 16'h0000);
        check("ill7_zero", 16'(bus1.ZeroOut), 16'h0001);
        check("ill7_carry", 16'(bus1.CarryOut), 16'h0000);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
